// File: rtl/alu_pkg.sv
// Shared opcode definitions and helpers for the ALU issue/writeback stage.
package alu_pkg;

  typedef enum logic [4:0] {
    ADD  = 5'b00000,
    SUB  = 5'b00001,
    AND  = 5'b00010,
    OR   = 5'b00011,
    RXOR = 5'b00100,
    XOR  = 5'b00101,
    NOT  = 5'b00110,
    SHL  = 5'b01110,
    SHR  = 5'b01111,
    CMP  = 5'b10000
  } opcode_t;

  localparam logic [4:0] OP_NOP = 5'b11111;

  // Ops whose result lands in the register file (and that update the flags).
  function automatic logic is_write_op(input logic [4:0] op);
    return (op <= NOT) || (op == SHL) || (op == SHR);
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decoded-instruction handshake between the decoder and the issue stage.
interface alu_issue_stage_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_op;
  logic [2:0] in_rd;
  logic [2:0] in_rs;
  logic [2:0] in_rt;
  logic       in_imm_en;
  logic [7:0] in_imm;

  modport master (
    output in_valid, in_op, in_rd, in_rs, in_rt, in_imm_en, in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs, in_rt, in_imm_en, in_imm,
    output in_ready
  );
endinterface

// File: rtl/alu_regfile.sv
// NREGS x 8 register file: two operand read ports, a debug read port and
// one synchronous write port, cleared to zero by the asynchronous reset.
module alu_regfile #(
  parameter int NREGS = 8,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  input  logic [AW-1:0] dbg_addr,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic [7:0]    rd_data_a,
  output logic [7:0]    rd_data_b,
  output logic [7:0]    dbg_data
);

  logic [7:0] regs [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];
  assign dbg_data  = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand issue and writeback stage in front of the 8-bit ALU, with
// result forwarding so dependent instructions issue back-to-back.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int RETW  = 16
) (
  input  logic                clk,
  input  logic                reset,
  alu_issue_stage_if.slave    issue,
  input  logic                hold,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic [4:0]          alu_op,
  input  logic [7:0]          alu_rslt,
  input  logic                alu_equal,
  input  logic                alu_less,
  output logic                flag_eq,
  output logic                flag_lt,
  output logic                err,
  output logic [RETW-1:0]     retired,
  input  logic [2:0]          dbg_addr,
  output logic [7:0]          dbg_data
);

  logic       exec_valid;
  logic [2:0] exec_rd;
  logic       exec_write;
  logic       accept;
  logic [7:0] rf_a;
  logic [7:0] rf_b;
  logic [7:0] opnd_a;
  logic [7:0] opnd_b;

  assign issue.in_ready = ~hold;
  assign accept         = issue.in_valid & ~hold;
  assign exec_write     = exec_valid & is_write_op(alu_op);

  alu_regfile #(.NREGS(NREGS)) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_a (issue.in_rs),
    .rd_addr_b (issue.in_rt),
    .dbg_addr  (dbg_addr),
    .we        (exec_write),
    .wr_addr   (exec_rd),
    .wr_data   (alu_rslt),
    .rd_data_a (rf_a),
    .rd_data_b (rf_b),
    .dbg_data  (dbg_data)
  );

  // The in-flight result bypasses the register file, which only sees it at the edge.
  always_comb begin
    opnd_a = rf_a;
    opnd_b = rf_b;
    if (exec_write && (exec_rd == issue.in_rs)) opnd_a = alu_rslt;
    if (issue.in_imm_en) begin
      opnd_b = issue.in_imm;
    end else if (exec_write && (exec_rd == issue.in_rt)) begin
      opnd_b = alu_rslt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= OP_NOP;
      exec_rd    <= '0;
      exec_valid <= 1'b0;
      flag_eq    <= 1'b0;
      flag_lt    <= 1'b0;
      err        <= 1'b0;
      retired    <= '0;
    end else begin
      exec_valid <= accept;
      if (accept) begin
        alu_a   <= opnd_a;
        alu_b   <= opnd_b;
        alu_op  <= issue.in_op;
        exec_rd <= issue.in_rd;
      end
      // Completion of the instruction currently in the exec slot.
      if (exec_valid) begin
        retired <= retired + RETW'(1);
        if (is_write_op(alu_op) || (alu_op == CMP)) begin
          flag_eq <= alu_equal;
          flag_lt <= alu_less;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with a behavioural ALU beside it.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic [7:0]  alu_a, alu_b, alu_rslt;
  logic [4:0]  alu_op;
  logic        alu_equal, alu_less;
  logic        flag_eq, flag_lt, err;
  logic [15:0] retired;
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_data;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [4:0]  op;
    logic        eq;
    logic        lt;
    logic        err;
    logic [15:0] ret;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  alu_issue_stage_if issue_if ();

  alu_issue_stage #(.NREGS(8), .RETW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .issue     (issue_if),
    .hold      (hold),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_rslt  (alu_rslt),
    .alu_equal (alu_equal),
    .alu_less  (alu_less),
    .flag_eq   (flag_eq),
    .flag_lt   (flag_lt),
    .err       (err),
    .retired   (retired),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  // Behavioural ALU; undefined ops return a recognisable 0xAA.
  always_comb begin
    alu_rslt = 8'hAA;
    case (alu_op)
      ADD:     alu_rslt = alu_a + alu_b;
      SUB:     alu_rslt = alu_a - alu_b;
      AND:     alu_rslt = alu_a & alu_b;
      OR:      alu_rslt = alu_a | alu_b;
      RXOR:    alu_rslt = {7'b0, ^alu_a};
      XOR:     alu_rslt = alu_a ^ alu_b;
      NOT:     alu_rslt = ~alu_a;
      SHL:     alu_rslt = {alu_a[6:0], 1'b0};
      SHR:     alu_rslt = {1'b0, alu_a[7:1]};
      default: alu_rslt = 8'hAA;
    endcase
    alu_equal = (alu_a == alu_b);
    alu_less  = (alu_a < alu_b);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkReg(input logic [2:0] addr, input logic [7:0] expected);
    dbg_addr = addr;
    #1;
    checkOutput($sformatf("rf[%0d]", addr), 32'(dbg_data), 32'(expected));
  endtask

  task automatic driveInstr(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs,
                            input logic [2:0] rt, input logic imm_en, input logic [7:0] imm);
    issue_if.in_valid  = 1'b1;
    issue_if.in_op     = op;
    issue_if.in_rd     = rd;
    issue_if.in_rs     = rs;
    issue_if.in_rt     = rt;
    issue_if.in_imm_en = imm_en;
    issue_if.in_imm    = imm;
  endtask

  task automatic pushExp(input string name, input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic eq, input logic lt, input logic e, input logic [15:0] ret);
    exp_t item;
    item.name = name; item.a = a; item.b = b; item.op = op;
    item.eq = eq; item.lt = lt; item.err = e; item.ret = ret;
    sb_q.push_back(item);
  endtask

  task automatic applyStimulus(input string name, input logic [4:0] op, input logic [2:0] rd,
                               input logic [2:0] rs, input logic [2:0] rt, input logic imm_en,
                               input logic [7:0] imm, input logic [7:0] exp_a, input logic [7:0] exp_b,
                               input logic exp_eq, input logic exp_lt, input logic exp_err,
                               input logic [15:0] exp_ret);
    driveInstr(op, rd, rs, rt, imm_en, imm);
    pushExp(name, op, exp_a, exp_b, exp_eq, exp_lt, exp_err, exp_ret);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    issue_if.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor: operands are checked in the exec cycle, flags/counters one cycle later.
  logic exec_pend  = 1'b0;
  logic comp_valid = 1'b0;
  exp_t cur;

  always @(posedge clk) exec_pend = issue_if.in_valid && !hold && !reset;

  always @(negedge clk) begin
    if (reset) begin
      exec_pend  = 1'b0;
      comp_valid = 1'b0;
    end else begin
      if (comp_valid) begin
        checkOutput({cur.name, " flag_eq"}, 32'(flag_eq), 32'(cur.eq));
        checkOutput({cur.name, " flag_lt"}, 32'(flag_lt), 32'(cur.lt));
        checkOutput({cur.name, " err"}, 32'(err), 32'(cur.err));
        checkOutput({cur.name, " retired"}, 32'(retired), 32'(cur.ret));
        comp_valid = 1'b0;
      end
      if (exec_pend) begin
        exec_pend = 1'b0;
        if (sb_q.size() == 0) begin
          checkOutput("unexpected accept", 32'(1), 32'(0));
        end else begin
          cur = sb_q.pop_front();
          checkOutput({cur.name, " alu_a"}, 32'(alu_a), 32'(cur.a));
          checkOutput({cur.name, " alu_b"}, 32'(alu_b), 32'(cur.b));
          checkOutput({cur.name, " alu_op"}, 32'(alu_op), 32'(cur.op));
          comp_valid = 1'b1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    hold  = 1'b0;
    dbg_addr = '0;
    issue_if.in_valid = 1'b0;
    driveInstr(ADD, 3'd0, 3'd0, 3'd0, 1'b1, 8'h00);
    issue_if.in_valid = 1'b0;
    #12;
    for (int i = 0; i < 8; i++) checkReg(3'(i), 8'h00);
    checkOutput("reset flag_eq", 32'(flag_eq), 32'(0));
    checkOutput("reset flag_lt", 32'(flag_lt), 32'(0));
    checkOutput("reset err", 32'(err), 32'(0));
    checkOutput("reset retired", 32'(retired), 32'(0));
    checkOutput("reset alu_op", 32'(alu_op), 32'(5'b11111));
    checkOutput("reset alu_a", 32'(alu_a), 32'(0));
    checkOutput("reset in_ready", 32'(issue_if.in_ready), 32'(1));
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Back-to-back dependency: r2 = r1 + 3 takes r1 from the bypass.
    applyStimulus("add r1", ADD, 3'd1, 3'd0, 3'd0, 1'b1, 8'h05, 8'h00, 8'h05, 1'b0, 1'b1, 1'b0, 16'd1);
    applyStimulus("add r2 fwd", ADD, 3'd2, 3'd1, 3'd0, 1'b1, 8'h03, 8'h05, 8'h03, 1'b0, 1'b0, 1'b0, 16'd2);
    idle(2);
    checkReg(3'd1, 8'h05);
    checkReg(3'd2, 8'h08);
    checkOutput("retired after two", 32'(retired), 32'(2));

    applyStimulus("or r3", OR, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 8'h05, 8'h08, 1'b0, 1'b1, 1'b0, 16'd3);
    applyStimulus("sub r5 fwd rt", SUB, 3'd5, 3'd1, 3'd3, 1'b0, 8'h00, 8'h05, 8'h0D, 1'b0, 1'b1, 1'b0, 16'd4);
    idle(2);
    checkReg(3'd3, 8'h0D);
    checkReg(3'd5, 8'hF8);

    applyStimulus("add r1 F0", ADD, 3'd1, 3'd0, 3'd0, 1'b1, 8'hF0, 8'h00, 8'hF0, 1'b0, 1'b1, 1'b0, 16'd5);
    idle(1);
    applyStimulus("sub r3", SUB, 3'd3, 3'd1, 3'd0, 1'b1, 8'h10, 8'hF0, 8'h10, 1'b0, 1'b0, 1'b0, 16'd6);
    applyStimulus("cmp r3", CMP, 3'd6, 3'd3, 3'd0, 1'b1, 8'hE0, 8'hE0, 8'hE0, 1'b1, 1'b0, 1'b0, 16'd7);
    idle(2);
    checkReg(3'd3, 8'hE0);
    checkReg(3'd6, 8'h00);

    // Undefined op: sticky err, flags untouched, and no forwarding from it.
    applyStimulus("undef op", 5'b01000, 3'd7, 3'd1, 3'd0, 1'b1, 8'h11, 8'hF0, 8'h11, 1'b1, 1'b0, 1'b1, 16'd8);
    applyStimulus("add r7 after err", ADD, 3'd7, 3'd7, 3'd0, 1'b1, 8'h01, 8'h00, 8'h01, 1'b0, 1'b1, 1'b1, 16'd9);

    driveInstr(ADD, 3'd6, 3'd1, 3'd0, 1'b1, 8'h02);
    hold = 1'b1;
    #1;
    checkOutput("hold in_ready", 32'(issue_if.in_ready), 32'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      checkOutput($sformatf("hold cycle %0d in_ready", i), 32'(issue_if.in_ready), 32'(0));
      checkOutput($sformatf("hold cycle %0d retired", i), 32'(retired), 32'(9));
    end
    hold = 1'b0;
    pushExp("add r6 after hold", ADD, 8'hF0, 8'h02, 1'b0, 1'b0, 1'b1, 16'd10);
    @(posedge clk);
    #2;
    idle(2);
    checkReg(3'd7, 8'h01);
    checkReg(3'd6, 8'hF2);
    checkOutput("retired after hold", 32'(retired), 32'(10));

    // Reset lands during the exec cycle: the instruction must not write back.
    applyStimulus("add r4 reset", ADD, 3'd4, 3'd0, 3'd0, 1'b1, 8'h7F, 8'h00, 8'h7F, 1'b0, 1'b1, 1'b1, 16'd11);
    issue_if.in_valid = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async reset alu_op", 32'(alu_op), 32'(5'b11111));
    checkOutput("async reset retired", 32'(retired), 32'(0));
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    checkReg(3'd4, 8'h00);
    checkReg(3'd1, 8'h00);
    checkOutput("reset mid-op retired", 32'(retired), 32'(0));
    checkOutput("reset mid-op err", 32'(err), 32'(0));
    reset = 1'b0;
    idle(2);
    checkReg(3'd4, 8'h00);
    checkOutput("retired stays 0", 32'(retired), 32'(0));
    checkOutput("scoreboard drained", 32'(sb_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
